// File: rtl/sys_defs.sv
// ============================================================================
// Module      : sys_defs (package)
// Description : Shared definitions for the feature-vector bank loader: build
//               macros with default values, loader FSM state encoding, default
//               FV length and the flattened per-bank write record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef Num_Banks_FV
`define Num_Banks_FV 4
`endif

`ifndef FV_bandwidth
`define FV_bandwidth 16
`endif

`ifndef FV_info_bank_width
`define FV_info_bank_width 8
`endif

`ifndef Max_FV_num
`define Max_FV_num 64
`endif

package sys_defs;

  // Default number of DW-bit words making up one feature vector
  localparam int FV_WORDS_DEF = 4;

  // Width of the FV count input; one extra bit so Max_FV_num itself fits
  localparam int NUM_FV_W = $clog2(`Max_FV_num) + 1;

  // Default word and bank-address widths
  localparam int FV_DW_DEF = `FV_bandwidth;
  localparam int FV_AW_DEF = `FV_info_bank_width - 2;

  // Loader FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } fv_state_e;

  // One bank's write port, flattened into a single record
  typedef struct packed {
    logic                 wr_en;
    logic                 sos;
    logic                 eos;
    logic [FV_DW_DEF-1:0] fv_data;
    logic [FV_AW_DEF-1:0] addr;
  } bank_wr_t;

endpackage

`default_nettype wire

// File: rtl/fv_addr_gen.sv
// ============================================================================
// Module      : fv_addr_gen
// Description : Word / FV / bank counters of the bank loader. Tracks which word
//               of which FV is next, the bank it belongs to (FV mod NUM_BANKS)
//               and the bank word address (FV / NUM_BANKS) * FV_WORDS + word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fv_addr_gen #(
  parameter int NUM_BANKS = 4,
  parameter int FV_WORDS  = 4,
  parameter int AW        = 6,
  parameter int FVW       = 7,
  parameter int BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           advance,
  output logic [BW-1:0]  cur_bank,
  output logic [FVW-1:0] fv_idx,
  output logic [AW-1:0]  addr,
  output logic           first_word,
  output logic           last_word
);

  localparam int WW = (FV_WORDS > 1) ? $clog2(FV_WORDS) : 1;

  localparam logic [WW-1:0] C_LAST_WORD = WW'(FV_WORDS - 1);
  localparam logic [BW-1:0] C_LAST_BANK = BW'(NUM_BANKS - 1);
  localparam logic [AW-1:0] C_FV_STRIDE = AW'(FV_WORDS);

  logic [WW-1:0]  r_word;
  logic [FVW-1:0] r_fv;
  logic [BW-1:0]  r_bank;
  // Base address of the current FV inside its bank; steps by one FV length
  // each time the bank index wraps, so no divider is needed.
  logic [AW-1:0]  r_base;

  // Advance word counter per transfer; on word wrap step FV, bank and base
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word <= '0;
      r_fv   <= '0;
      r_bank <= '0;
      r_base <= '0;
    end else if (clear) begin
      r_word <= '0;
      r_fv   <= '0;
      r_bank <= '0;
      r_base <= '0;
    end else if (advance) begin
      if (r_word == C_LAST_WORD) begin
        r_word <= '0;
        r_fv   <= r_fv + 1'b1;
        if (r_bank == C_LAST_BANK) begin
          r_bank <= '0;
          r_base <= r_base + C_FV_STRIDE;
        end else begin
          r_bank <= r_bank + 1'b1;
        end
      end else begin
        r_word <= r_word + 1'b1;
      end
    end
  end

  assign cur_bank   = r_bank;
  assign fv_idx     = r_fv;
  assign addr       = r_base + AW'(r_word);
  assign first_word = (r_word == '0);
  assign last_word  = (r_word == C_LAST_WORD);

endmodule

`default_nettype wire

// File: rtl/fv_bank_loader.sv
// ============================================================================
// Module      : fv_bank_loader
// Description : Distributes a stream of feature-vector words from the SPI side
//               round-robin over NUM_BANKS FV banks, one FV per bank in turn.
//               Each accepted word is written one cycle later with its bank
//               word address and start/end-of-FV flags.
//               Build option: define FV_LOADER_ERR_EN to enable the sticky
//               protocol error flag (in_valid while idle, start while busy).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fv_bank_loader
  import sys_defs::*;
#(
  parameter int NUM_BANKS = `Num_Banks_FV,
  parameter int FV_WORDS  = FV_WORDS_DEF,
  parameter int DW        = `FV_bandwidth,
  parameter int AW        = `FV_info_bank_width - 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_FV_W-1:0]    Num_FV,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW-1:0]          in_data,
  input  logic [NUM_BANKS-1:0]   bank_busy,
  output logic [NUM_BANKS-1:0]   wr_en,
  output logic [NUM_BANKS-1:0]   sos,
  output logic [NUM_BANKS-1:0]   eos,
  output logic [NUM_BANKS*DW-1:0] FV_data,
  output logic [NUM_BANKS*AW-1:0] A,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  fv_state_e           r_state;
  logic [NUM_FV_W-1:0] r_num_fv;
  logic                r_busy;
  logic                r_done;

  logic                w_start_acc;
  logic                w_xfer;
  logic                w_final;
  logic [BW-1:0]       w_cur_bank;
  logic [NUM_FV_W-1:0] w_fv_idx;
  logic [AW-1:0]       w_addr;
  logic                w_first_word;
  logic                w_last_word;

  // A start only counts when idle; it also rewinds the counters
  assign w_start_acc = start && (r_state == ST_IDLE);
  assign in_ready    = (r_state == ST_LOAD) && !bank_busy[w_cur_bank];
  assign w_xfer      = in_valid && in_ready;
  assign w_final     = w_xfer && w_last_word && (w_fv_idx == (r_num_fv - 1'b1));

  fv_addr_gen #(
    .NUM_BANKS (NUM_BANKS),
    .FV_WORDS  (FV_WORDS),
    .AW        (AW),
    .FVW       (NUM_FV_W),
    .BW        (BW)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_start_acc),
    .advance    (w_xfer),
    .cur_bank   (w_cur_bank),
    .fv_idx     (w_fv_idx),
    .addr       (w_addr),
    .first_word (w_first_word),
    .last_word  (w_last_word)
  );

  // Loader FSM with registered busy/done; done lines up with the last write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_num_fv <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (Num_FV != '0) begin
              r_num_fv <= Num_FV;
              r_busy   <= 1'b1;
              r_state  <= ST_LOAD;
            end else begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_LOAD: begin
          if (w_final) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;

  // Per-bank write registers; only the selected bank strobes, others keep
  // their last data/address so downstream sees stable values.
  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic          w_sel;
    logic          r_we;
    logic          r_sos;
    logic          r_eos;
    logic [DW-1:0] r_data;
    logic [AW-1:0] r_addr;

    assign w_sel = w_xfer && (w_cur_bank == BW'(k));

    // Capture the transferred word for this bank one cycle after transfer
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_we   <= 1'b0;
        r_sos  <= 1'b0;
        r_eos  <= 1'b0;
        r_data <= '0;
        r_addr <= '0;
      end else begin
        r_we  <= w_sel;
        r_sos <= w_sel && w_first_word;
        r_eos <= w_sel && w_last_word;
        if (w_sel) begin
          r_data <= in_data;
          r_addr <= w_addr;
        end
      end
    end

    assign wr_en[k]           = r_we;
    assign sos[k]             = r_sos;
    assign eos[k]             = r_eos;
    assign FV_data[k*DW +: DW] = r_data;
    assign A[k*AW +: AW]       = r_addr;
  end

`ifdef FV_LOADER_ERR_EN
  logic r_err;

  // Sticky protocol error: data offered while idle, or start while loading
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if ((in_valid && (r_state == ST_IDLE)) || (start && r_busy)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fv_bank_loader.sv
// ============================================================================
// Module      : tb_fv_bank_loader
// Description : Self-checking bench for fv_bank_loader. Table of load
//               scenarios plus hand sequences; a scoreboard queue holds the
//               write expected for every word accepted by the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fv_bank_loader;

  localparam int NB = 4;
  localparam int FW = 4;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NW = 7;

`ifdef FV_LOADER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [NW-1:0]    Num_FV;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic [NB-1:0]    bank_busy;
  logic [NB-1:0]    wr_en, sos, eos;
  logic [NB*DW-1:0] FV_data;
  logic [NB*AW-1:0] A;
  logic             busy, done, err;

  fv_bank_loader #(
    .NUM_BANKS (NB),
    .FV_WORDS  (FW),
    .DW        (DW),
    .AW        (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .Num_FV    (Num_FV),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .bank_busy (bank_busy),
    .wr_en     (wr_en),
    .sos       (sos),
    .eos       (eos),
    .FV_data   (FV_data),
    .A         (A),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            bank;
    bit            sos;
    bit            eos;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    bit            last;
  } exp_t;

  typedef struct {
    int n;          // Num_FV
    int bf;         // FV index during which a bank goes busy (-1: never)
    int bw;         // word index at which it goes busy
    int blen;       // busy duration in cycles
    int exp_strobes;
    int exp_stalls;
  } vec_t;

  exp_t          q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            pops   = 0;
  bit            exp_err = 1'b0;
  logic [DW-1:0] hold_data[NB];
  logic [AW-1:0] hold_addr[NB];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (reset) begin
      if ($countones(wr_en) > 1) chk("one_strobe", 64'($countones(wr_en)), 64'd1);
      if (((sos | eos) & ~wr_en) != '0) chk("flags_idle_bank", 64'((sos | eos) & ~wr_en), 64'd0);
      for (int k = 0; k < NB; k++) begin
        if (wr_en[k]) begin
          if (q.size() == 0) begin
            chk("unexpected_strobe", 64'd1, 64'd0);
          end else begin
            mon_e = q.pop_front();
            pops++;
            chk("strobe",
                64'({4'(k), sos[k], eos[k], FV_data[k*DW +: DW], A[k*AW +: AW], done}),
                64'({4'(mon_e.bank), mon_e.sos, mon_e.eos, mon_e.data, mon_e.addr, mon_e.last}));
          end
        end
      end
    end
  end

  task automatic clear_model();
    q.delete();
    for (int k = 0; k < NB; k++) begin
      hold_data[k] = '0;
      hold_addr[k] = '0;
    end
  endtask

  // Runs one load; optional bank stall, mid-load start pulse, or reset abort
  task automatic run_load(input int n, input int bf, input int bw, input int blen,
                          input int start_at, input int abort_after,
                          input int exp_strobes, input int exp_stalls);
    int f = 0, w = 0, x = 0, stalls = 0, bleft = 0, cyc = 0, p0;
    int total = n * FW;
    bit busy_done = 1'b0;
    bit pulsed = 1'b0;
    p0 = pops;
    @(posedge clk); #1;
    start  = 1'b1;
    Num_FV = NW'(n);
    @(posedge clk); #1;
    start  = 1'b0;
    Num_FV = NW'(n + 3);
    chk("busy_after_start", 64'(busy), 64'(n > 0));
    in_valid = 1'b1;
    in_data  = DW'($urandom);
    while (x < total && cyc < total * 4 + 50) begin
      if (!busy_done && f == bf && w == bw) begin
        bank_busy[bf % NB] = 1'b1;
        bleft = blen;
        busy_done = 1'b1;
      end
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{bank: f % NB, sos: (w == 0), eos: (w == FW - 1), data: in_data,
                      addr: AW'((f / NB) * FW + w), last: (x == total - 1)});
        hold_data[f % NB] = in_data;
        hold_addr[f % NB] = AW'((f / NB) * FW + w);
        x++;
        w++;
        if (w == FW) begin
          w = 0;
          f++;
        end
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      if (bleft > 0) begin
        bleft--;
        if (bleft == 0) bank_busy = '0;
      end
      in_data = DW'($urandom);
      start = 1'b0;
      if (start_at > 0 && x == start_at && !pulsed && x < total) begin
        start   = 1'b1;
        Num_FV  = NW'(1);
        pulsed  = 1'b1;
        exp_err = exp_err | ERR_EN;
      end
      if (abort_after > 0 && x == abort_after) begin
        reset = 1'b0;
        #1;
        chk("reset_mid_load_zero",
            64'(|{wr_en, sos, eos, FV_data, A, busy, done, err, in_ready}), 64'd0);
        in_valid  = 1'b0;
        start     = 1'b0;
        bank_busy = '0;
        clear_model();
        exp_err = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        return;
      end
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("transfers", 64'(x), 64'(total));
    chk("done_with_last_write", 64'(done), 64'd1);
    chk("busy_cleared", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("done_single_cycle", 64'({done, in_ready}), 64'd0);
    @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    chk("strobe_count", 64'(pops - p0), 64'(exp_strobes));
    if (bf >= 0) chk("stall_cycles", 64'(stalls), 64'(exp_stalls));
    for (int k = 0; k < NB; k++)
      chk("bank_hold", 64'({FV_data[k*DW +: DW], A[k*AW +: AW]}),
          64'({hold_data[k], hold_addr[k]}));
    chk("err_flag", 64'(err), 64'(exp_err));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{n: 5,  bf: -1, bw: 0, blen: 0, exp_strobes: 20,  exp_stalls: 0};
    vecs[1] = '{n: 6,  bf: 1,  bw: 2, blen: 3, exp_strobes: 24,  exp_stalls: 3};
    vecs[2] = '{n: 1,  bf: -1, bw: 0, blen: 0, exp_strobes: 4,   exp_stalls: 0};
    vecs[3] = '{n: 9,  bf: -1, bw: 0, blen: 0, exp_strobes: 36,  exp_stalls: 0};
    vecs[4] = '{n: 4,  bf: 3,  bw: 3, blen: 2, exp_strobes: 16,  exp_stalls: 2};
    vecs[5] = '{n: 2,  bf: 0,  bw: 0, blen: 1, exp_strobes: 8,   exp_stalls: 1};
    vecs[6] = '{n: 70, bf: -1, bw: 0, blen: 0, exp_strobes: 280, exp_stalls: 0};

    reset     = 1'b0;
    start     = 1'b0;
    Num_FV    = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    bank_busy = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state_zero",
        64'(|{wr_en, sos, eos, FV_data, A, busy, done, err, in_ready}), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++)
      run_load(vecs[i].n, vecs[i].bf, vecs[i].bw, vecs[i].blen, 0, 0,
               vecs[i].exp_strobes, vecs[i].exp_stalls);

    // Num_FV = 0: done one cycle later, no writes, never ready
    @(posedge clk); #1;
    start  = 1'b1;
    Num_FV = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_fv_done", 64'({done, in_ready, busy}), 64'b100);
    @(posedge clk); #1;
    chk("zero_fv_done_clear", 64'({done, in_ready, busy}), 64'b000);
    @(negedge clk);
    chk("zero_fv_no_write", 64'(q.size()), 64'd0);

    // Start pulsed mid-load must be ignored
    run_load(5, -1, 0, 0, 7, 0, 20, 0);

    // in_valid while idle flags an error only when the option is built in
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_err  = exp_err | ERR_EN;
    chk("err_idle_valid", 64'(err), 64'(exp_err));
    run_load(3, -1, 0, 0, 0, 0, 12, 0);

    // Reset after 6 transfers, then a fresh load restarts at bank 0, A=0
    run_load(5, -1, 0, 0, 0, 6, 0, 0);
    @(negedge clk);
    chk("no_write_after_reset", 64'(wr_en), 64'd0);
    run_load(2, -1, 0, 0, 0, 0, 8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/fv_bank_loader.md
FV_BANK_LOADER -- requirements
Module: fv_bank_loader

Interface
REQ-001 Parameter NUM_BANKS, default `Num_Banks_FV (4): number of FV banks fed.
REQ-002 Parameter FV_WORDS, default 4: DW-bit words per feature vector.
REQ-003 Parameter DW, default `FV_bandwidth: word width. AW, default `FV_info_bank_width-2: bank word-address width.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a load.
REQ-007 Num_FV  in  $clog2(`Max_FV_num)+1  number of FVs to load; sampled on accepted start.
REQ-008 in_valid / in_ready / in_data  in / out / DW  word stream from the SPI side; transfer occurs when valid&&ready.
REQ-009 bank_busy  in  NUM_BANKS  target bank cannot accept a write.
REQ-010 wr_en, sos, eos  out  NUM_BANKS each  per-bank write strobe, first-word flag, last-word flag.
REQ-011 FV_data  out  NUM_BANKS*DW; A  out  NUM_BANKS*AW  per-bank data and word address, bank k in slice k.
REQ-012 busy  out  1  high in LOAD; done  out  1  one-cycle completion pulse; err  out  1  sticky protocol error (REQ-029).

Function
REQ-013 FSM states IDLE, LOAD, DONE; reset state IDLE.
REQ-014 IDLE: start with Num_FV>0 latches Num_FV and goes to LOAD; start with Num_FV==0 goes directly to DONE.
REQ-015 LOAD: in_ready = !bank_busy[cur_bank]; in_ready is 0 in IDLE and DONE.
REQ-016 FV index f maps to bank f mod NUM_BANKS; word w of FV f writes A = (f / NUM_BANKS)*FV_WORDS + w, truncated to AW bits.
REQ-017 Each accepted word is presented registered on the cycle after the transfer: wr_en[cur_bank]=1, sos=1 iff w==0, eos=1 iff w==FV_WORDS-1, FV_data slice = word, A slice per REQ-016.
REQ-018 Latency from transfer to wr_en is exactly one cycle; at most one bank strobes per cycle.
REQ-019 Non-strobed banks hold wr_en/sos/eos at 0; their FV_data and A slices hold their last values.
REQ-020 Word counter wraps 0..FV_WORDS-1; on wrap, FV counter increments and cur_bank advances modulo NUM_BANKS.
REQ-021 Transfer of last word of FV Num_FV-1 moves FSM to DONE; DONE asserts done for one cycle and returns to IDLE.
REQ-022 done coincides with the final wr_en/eos cycle.
REQ-023 start while in LOAD or DONE is ignored.
REQ-024 bank_busy rising mid-FV stalls only via in_ready; counters hold, no word is lost or duplicated.
REQ-025 With FV_WORDS==1, sos and eos both assert on every strobe.

Reset
REQ-026 reset low asynchronously forces IDLE, all counters 0, all outputs 0 (wr_en, sos, eos, FV_data, A, busy, done, err, in_ready).
REQ-027 Reset asserted mid-LOAD abandons the load; no partial write is issued after deassertion.
REQ-028 Outputs become valid on the first rising clk after reset deasserts.

Configuration
REQ-029 With FV_LOADER_ERR_EN defined: in_valid high in IDLE, or start while busy, sets err, which is cleared only by reset.
REQ-030 Without FV_LOADER_ERR_EN: err is tied to 0 and no detection logic exists; all other behaviour is identical.

Structure
REQ-031 FSM state enum, FV_WORDS default and a flattened bank-write struct (wr_en, sos, eos, FV_data, A) belong in the shared sys_defs package.
REQ-032 One sub-module, fv_addr_gen, holds the word/FV/bank counters and address computation; the top holds the FSM and output registers.

Verification
REQ-033 Num_FV=5, FV_WORDS=4, no busy, in_valid constant: 20 strobes; FV4 on bank 0 at A=4..7; done on cycle 21 after first transfer.
REQ-034 Num_FV=0 start: done one cycle later, zero wr_en, in_ready never high.
REQ-035 bank_busy[1] held 3 cycles during FV1 word 2: in_ready low 3 cycles, words 2-3 then written to bank 1 at A=2,3 in order.
REQ-036 reset pulled low after 6 transfers: all outputs 0 immediately; new start with Num_FV=2 restarts at bank 0, A=0.
REQ-037 FV_LOADER_ERR_EN defined, in_valid=1 in IDLE: err=1 next cycle and stays 1 through a subsequent normal load; undefined: err stays 0.
REQ-038 start pulsed mid-LOAD: ignored, Num_FV unchanged, load completes with original count.
